// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the fetch FSM state encodings, the bubble instruction and the
// default reset PC, plus a word-alignment helper.
package if_stage_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // issue a request at pc
    ST_WAIT = 2'd1,  // request outstanding, waiting for imem_valid
    ST_KILL = 2'd2,  // outstanding request made stale by a redirect
    ST_BUF  = 2'd3   // fetched word parked in skid while ID is stalled
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag.
// Ports:
//   clock, reset   posedge clock, synchronous active-high reset
//   flush          load a bubble; wins over hold
//   hold           keep current contents (load-use stall)
//   load           capture im_in/pc4_in as a valid instruction;
//                  with neither hold nor load a bubble is loaded
//   im_in, pc4_in  next instruction and its PC+4
//   im_out, pc4_out, valid_out  registered contents
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] im_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] im_out,
  output logic [31:0] pc4_out,
  output logic        valid_out
);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      im_out    <= NOP;
      pc4_out   <= '0;
      valid_out <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        im_out    <= im_in;
        pc4_out   <= pc4_in;
        valid_out <= 1'b1;
      end else begin
        im_out    <= NOP;
        pc4_out   <= '0;
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word
// reads to instruction memory and fills the IF/ID register. Honours ID
// stalls (fetched word parked in a skid register) and ID redirects
// (IF/ID flushed, in-flight fetch discarded).
// Ports:
//   clock, reset           posedge clock, synchronous active-high reset
//   stall                  hold IF/ID (load-use hazard)
//   redirect, redirect_pc  taken branch/jump/JR target from ID
//   imem_req, imem_addr    combinational read request to memory
//   imem_valid, imem_rdata read response (latency >= 1 cycle)
//   IF_ID_im_out, IF_ID_pc4, IF_ID_valid  registered IF/ID contents
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_im_out,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  skid, skid_n;
  logic [31:0]  pc_plus4;

  logic         ifid_flush;
  logic         ifid_hold;
  logic         ifid_load;
  logic [31:0]  ifid_im;
  logic [31:0]  ifid_pc4;

  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_REQ;
      pc    <= RESET_PC;
      skid  <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      skid  <= skid_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    skid_n     = skid;
    imem_req   = 1'b0;
    imem_addr  = pc;
    ifid_flush = 1'b0;
    ifid_hold  = 1'b0;
    ifid_load  = 1'b0;
    ifid_im    = imem_rdata;
    ifid_pc4   = pc_plus4;

    if (redirect) begin
      // Request stays low here; a fetch still in flight without data
      // this cycle must be drained in KILL before the target is fetched.
      pc_n       = word_align(redirect_pc);
      skid_n     = '0;
      ifid_flush = 1'b1;
      if ((state == ST_WAIT || state == ST_KILL) && !imem_valid)
        state_n = ST_KILL;
      else
        state_n = ST_REQ;
    end else begin
      unique case (state)
        ST_REQ: begin
          // Any imem_valid seen here predates a reset and is ignored.
          imem_req  = 1'b1;
          imem_addr = pc;
          ifid_hold = stall;
          state_n   = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_valid) begin
            pc_n = pc_plus4;
            if (stall) begin
              skid_n    = imem_rdata;
              ifid_hold = 1'b1;
              state_n   = ST_BUF;
            end else begin
              ifid_load = 1'b1;
              imem_req  = 1'b1;
              imem_addr = pc_plus4;
            end
          end else begin
            ifid_hold = stall;
          end
        end
        ST_BUF: begin
          // pc was already advanced when the word was parked, so pc is
          // the parked word's PC+4.
          if (stall) begin
            ifid_hold = 1'b1;
          end else begin
            ifid_load = 1'b1;
            ifid_im   = skid;
            ifid_pc4  = pc;
            state_n   = ST_REQ;
          end
        end
        ST_KILL: begin
          ifid_hold = 1'b1;
          if (imem_valid)
            state_n = ST_REQ;
        end
        default: begin
          state_n = ST_REQ;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP (NOP)
  ) u_if_id_reg (
    .clock     (clock),
    .reset     (reset),
    .flush     (ifid_flush),
    .hold      (ifid_hold),
    .load      (ifid_load),
    .im_in     (ifid_im),
    .pc4_in    (ifid_pc4),
    .im_out    (IF_ID_im_out),
    .pc4_out   (IF_ID_pc4),
    .valid_out (IF_ID_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] NOPI   = 32'h0000_0000;
  localparam logic [31:0] TAG    = 32'hC0DE_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_im_out;
  logic [31:0] IF_ID_pc4;
  logic        IF_ID_valid;

  always #5 clock = ~clock;

  if_stage #(
    .RESET_PC (RST_PC),
    .NOP      (NOPI)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .IF_ID_im_out (IF_ID_im_out),
    .IF_ID_pc4    (IF_ID_pc4),
    .IF_ID_valid  (IF_ID_valid)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Reference program order: after reset or a redirect, ID must see the
  // words at target, target+4, ... (mod 2^32), each exactly once.
  typedef struct packed {
    logic [31:0] im;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] gen_pc;

  function automatic void restart(input logic [31:0] target);
    exp_q.delete();
    gen_pc = target & 32'hFFFF_FFFC;
  endfunction

  function automatic void refill();
    exp_t e;
    while (exp_q.size() < 16) begin
      e.im  = gen_pc ^ TAG;
      e.pc4 = gen_pc + 32'd4;
      exp_q.push_back(e);
      gen_pc = gen_pc + 32'd4;
    end
  endfunction

  // Memory model: one request at a time, random latency, addr-tagged data.
  int  lat_lo = 1;
  int  lat_hi = 1;
  bit  inject_late = 1'b0;
  bit  pending = 1'b0;
  logic [31:0] pend_addr;
  int  cnt;

  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clock);
      #2;
      if (reset) begin
        pending    = 1'b0;
        imem_valid = 1'b0;
      end else if (pending) begin
        cnt--;
        if (cnt <= 0) begin
          imem_valid = 1'b1;
          imem_rdata = pend_addr ^ TAG;
          pending    = 1'b0;
        end else begin
          imem_valid = 1'b0;
          imem_rdata = $urandom();
        end
      end else if (inject_late) begin
        imem_valid  = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        inject_late = 1'b0;
      end else begin
        imem_valid = 1'b0;
        imem_rdata = $urandom();
      end
      @(negedge clock);
      if (!reset && imem_req) begin
        check("one_outstanding", {31'b0, pending}, 32'd0);
        pending   = 1'b1;
        pend_addr = imem_addr;
        cnt       = int'($urandom_range(lat_hi, lat_lo));
      end
    end
  end

  // Monitor: evaluates the effect of each clock edge from the inputs that
  // were applied before it, and checks combinational request outputs.
  logic        p_reset = 1'b1;
  logic        p_stall = 1'b0;
  logic        p_redirect = 1'b0;
  logic [31:0] p_rpc = '0;
  logic [31:0] snap_im, snap_pc4;
  logic        snap_valid;
  int          deliveries = 0;
  int          total_deliv = 0;
  int          gap = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (p_reset) begin
        check("reset_valid", {31'b0, IF_ID_valid}, 32'd0);
        check("reset_im", IF_ID_im_out, NOPI);
        check("reset_pc4", IF_ID_pc4, 32'd0);
        restart(RST_PC);
        deliveries = 0;
        gap = 0;
      end else if (p_redirect) begin
        check("flush_valid", {31'b0, IF_ID_valid}, 32'd0);
        check("flush_im", IF_ID_im_out, NOPI);
        check("flush_pc4", IF_ID_pc4, 32'd0);
        restart(p_rpc);
        gap = 0;
      end else if (p_stall) begin
        check("stall_hold_im", IF_ID_im_out, snap_im);
        check("stall_hold_pc4", IF_ID_pc4, snap_pc4);
        check("stall_hold_valid", {31'b0, IF_ID_valid}, {31'b0, snap_valid});
      end else if (IF_ID_valid) begin
        refill();
        e = exp_q.pop_front();
        check("deliver_im", IF_ID_im_out, e.im);
        check("deliver_pc4", IF_ID_pc4, e.pc4);
        deliveries++;
        total_deliv++;
        gap = 0;
      end else begin
        check("bubble_im", IF_ID_im_out, NOPI);
        gap++;
        if (gap > 16) begin
          check("fetch_progress_gap", gap, 32'd0);
          gap = 0;
        end
      end

      if (!reset) begin
        if (p_reset && !redirect) begin
          check("first_req", {31'b0, imem_req}, 32'd1);
          check("first_addr", imem_addr, RST_PC);
        end
        if (redirect)
          check("req_low_on_redirect", {31'b0, imem_req}, 32'd0);
        else if (imem_req)
          check("addr_aligned", {30'b0, imem_addr[1:0]}, 32'd0);
      end

      snap_im    = IF_ID_im_out;
      snap_pc4   = IF_ID_pc4;
      snap_valid = IF_ID_valid;
      p_reset    = reset;
      p_stall    = stall;
      p_redirect = redirect;
      p_rpc      = redirect_pc;
    end
  end

  task automatic cyc(input logic st, input logic rd, input logic [31:0] rp);
    @(posedge clock);
    #1;
    stall       = st;
    redirect    = rd;
    redirect_pc = rp;
  endtask

  task automatic do_reset(input bit inj);
    @(posedge clock);
    #1;
    reset    = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    inject_late = inj;
    reset       = 1'b0;
  endtask

  initial begin
    logic        st, rd;
    logic [31:0] rp;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    // Sequential fetch, 1-cycle memory: one word per cycle from RESET_PC.
    do_reset(1'b0);
    repeat (4) @(posedge clock);
    @(negedge clock);
    #1;
    check("startup_deliveries", deliveries, 32'd3);
    check("startup_im3", IF_ID_im_out, 32'h0000_3008 ^ TAG);
    check("startup_pc4_3", IF_ID_pc4, 32'h0000_300C);

    // Stall held for 3 cycles with data returning.
    repeat (3) cyc(1'b1, 1'b0, $urandom());
    repeat (4) cyc(1'b0, 1'b0, $urandom());

    // Redirect while a slow fetch is outstanding.
    lat_lo = 3;
    lat_hi = 3;
    repeat (3) cyc(1'b0, 1'b0, $urandom());
    cyc(1'b0, 1'b1, 32'h0000_3100);
    repeat (12) cyc(1'b0, 1'b0, $urandom());

    // Redirect and stall together.
    cyc(1'b1, 1'b1, 32'h0000_3200);
    repeat (10) cyc(1'b0, 1'b0, $urandom());

    // Redirect coinciding with returning data.
    lat_lo = 1;
    lat_hi = 1;
    repeat (4) cyc(1'b0, 1'b0, $urandom());
    cyc(1'b0, 1'b1, 32'h0000_3300);
    repeat (6) cyc(1'b0, 1'b0, $urandom());

    // PC wrap, low target bits ignored.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFE);
    repeat (6) cyc(1'b0, 1'b0, $urandom());

    // Reset mid-stream with a stray late response.
    lat_lo = 3;
    lat_hi = 3;
    repeat (2) cyc(1'b0, 1'b0, $urandom());
    lat_lo = 1;
    lat_hi = 2;
    do_reset(1'b1);
    repeat (8) cyc(1'b0, 1'b0, $urandom());

    // Randomized traffic.
    lat_lo = 1;
    lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(599, 0) == 0) do_reset($urandom_range(1, 0) == 1);
      st = ($urandom_range(99, 0) < 20);
      rd = ($urandom_range(99, 0) < 7);
      if ($urandom_range(3, 0) == 0) rp = 32'hFFFF_FFF8 | 32'($urandom_range(7, 0));
      else rp = $urandom();
      cyc(st, rd, rp);
    end
    repeat (10) cyc(1'b0, 1'b0, $urandom());
    @(negedge clock);
    #1;
    check("enough_deliveries", (total_deliv > 400) ? 32'd1 : 32'd0, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
